// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with a valid/ready request port and a
// valid/ready result port. Logic and shift ops finish in one cycle; multiply
// and divide iterate one bit per cycle for XLEN cycles.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE, out_valid only in DONE, and while out_valid is high
// and out_ready low, op_result and out_valid hold.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_result,
  output logic [1:0]      dbg_state_o
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;       // original op_a (remainder for divide-by-zero)
  logic [XLEN-1:0] b_q, b_d;       // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_q, acc_d;   // product high half or partial remainder
  logic [XLEN-1:0] quo_q, quo_d;   // multiplier/product low half or quotient
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d; // negate quotient at the end
  logic            neg_r_q, neg_r_d; // negate remainder at the end
  logic [XLEN-1:0] result_q, result_d;

  logic            accept, long_in, last_iter, is_mul, b_zero;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] quick_res, final_res, a_abs, b_abs;
  logic [XLEN:0]   mul_sum, rem_sh, rem_sub;
  logic [XLEN-1:0] mul_acc_n, mul_quo_n, div_acc_n, div_quo_n;
  logic            div_ge;
  logic            unused_rem_top;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign long_in   = op[3] & (op[2] | op[1]);
  assign last_iter = (cnt_q == CW'(XLEN - 1));
  assign is_mul    = (op_q[3:1] == 3'b101);
  assign b_zero    = (b_q == '0);
  assign shamt     = op_b[SW-1:0];
  assign a_abs     = op_a[XLEN-1] ? -op_a : op_a;
  assign b_abs     = op_b[XLEN-1] ? -op_b : op_b;

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign op_result   = result_q;
  assign dbg_state_o = state_q;

  // Shift-add multiply step: add multiplicand on LSB, shift {acc,quo} right.
  assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, b_q} : '0);
  assign mul_acc_n = mul_sum[XLEN:1];
  assign mul_quo_n = {mul_sum[0], quo_q[XLEN-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  assign rem_sh    = {acc_q, quo_q[XLEN-1]};
  assign rem_sub   = rem_sh - {1'b0, b_q};
  assign div_ge    = (rem_sh >= {1'b0, b_q});
  assign div_acc_n = div_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign div_quo_n = {quo_q[XLEN-2:0], div_ge};
  // Top bit of the difference is always 0 when it is selected.
  assign unused_rem_top = rem_sub[XLEN];

  // Single-cycle results computed straight from the request inputs.
  always_comb begin
    quick_res = '0;
    case (op)
      4'd0: quick_res = op_a + op_b;
      4'd1: quick_res = op_a - op_b;
      4'd2: quick_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd3: quick_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd4: quick_res = op_a & op_b;
      4'd5: quick_res = op_a | op_b;
      4'd6: quick_res = op_a ^ op_b;
      4'd7: quick_res = op_a << shamt;
      4'd8: quick_res = op_a >> shamt;
      4'd9: quick_res = $unsigned($signed(op_a) >>> shamt);
      default: quick_res = '0;
    endcase
  end

  // Final multi-cycle result, taken from the values of the last iteration.
  always_comb begin
    final_res = '0;
    case (op_q)
      4'd10: final_res = mul_quo_n;
      4'd11: final_res = mul_acc_n;
      4'd12: final_res = b_zero ? '1 : div_quo_n;
      4'd13: final_res = b_zero ? a_q : div_acc_n;
      4'd14: final_res = b_zero ? '1 : (neg_q_q ? -div_quo_n : div_quo_n);
      4'd15: final_res = b_zero ? a_q : (neg_r_q ? -div_acc_n : div_acc_n);
      default: final_res = '0;
    endcase
  end

  // FSM next state: IDLE -> DONE (short op) or BUSY (mul/div) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = long_in ? S_BUSY : S_DONE;
      S_BUSY: if (last_iter) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: capture on accept, iterate in BUSY, hold otherwise.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    if (accept) begin
      op_d    = op;
      a_d     = op_a;
      acc_d   = '0;
      cnt_d   = '0;
      neg_q_d = op[1] & (op_a[XLEN-1] ^ op_b[XLEN-1]);
      neg_r_d = op[1] & op_a[XLEN-1];
      if (long_in && op[2] && op[1]) begin
        quo_d = a_abs;
        b_d   = b_abs;
      end else begin
        quo_d = op_a;
        b_d   = op_b;
      end
      if (!long_in) result_d = quick_res;
    end else if (state_q == S_BUSY) begin
      cnt_d = cnt_q + 1'b1;
      if (is_mul) begin
        acc_d = mul_acc_n;
        quo_d = mul_quo_n;
      end else begin
        acc_d = div_acc_n;
        quo_d = div_quo_n;
      end
      if (last_iter) result_d = final_res;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous assert, active-high.
REQ-004 SHALL have in_valid  input  1  operation request valid.
REQ-005 SHALL have in_ready  output  1  block can accept a request.
REQ-006 SHALL have op  input  4  operation code per REQ-012.
REQ-007 SHALL have op_a  input  XLEN  first operand.
REQ-008 SHALL have op_b  input  XLEN  second operand / shift amount.
REQ-009 SHALL have out_valid  output  1  op_result holds a completed result.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have op_result  output  XLEN  registered result.

Function
REQ-012 SHALL decode op: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned), 12 DIVU, 13 REMU, 14 DIV, 15 REM.
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL accept a request on a cycle with in_valid && in_ready, capturing op, op_a, op_b; inputs are ignored at all other times.
REQ-015 Ops 0-9 SHALL go IDLE -> DONE on the accept edge; out_valid asserts the cycle after accept (latency 1).
REQ-016 Ops 10-15 SHALL go IDLE -> BUSY, iterate exactly XLEN cycles (one bit per cycle: shift-add multiply, restoring divide), then BUSY -> DONE; out_valid asserts XLEN+1 cycles after accept.
REQ-017 DONE -> IDLE SHALL occur on the edge where out_ready = 1; while out_ready = 0, op_result and out_valid SHALL hold unchanged.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN; no carry/overflow outputs.
REQ-019 SLT SHALL compare signed, SLTU unsigned; result 1 or 0, zero-extended to XLEN.
REQ-020 Shifts SHALL use only op_b[log2(XLEN)-1:0]; SRA fills with op_a[XLEN-1]; SLL/SRL fill with 0.
REQ-021 MUL/MULHU SHALL form the full 2*XLEN unsigned product; MUL returns low half, MULHU high half.
REQ-022 DIV/REM SHALL divide magnitudes, then negate quotient if operand signs differ, and negate remainder to sign of op_a (truncate toward zero).
REQ-023 Divisor 0 SHALL yield quotient all-ones (DIV and DIVU) and remainder = op_a (REM and REMU), still after the full XLEN-cycle latency.
REQ-024 DIV of most-negative by -1 SHALL yield quotient = most-negative value and remainder 0, no exception.
REQ-025 Requests presented while in_ready = 0 SHALL NOT be captured or queued; the requester holds in_valid until accepted.
REQ-026 The iteration counter SHALL be log2(XLEN)+1 bits and SHALL NOT wrap before reaching XLEN.

Reset
REQ-027 rst = 1 SHALL asynchronously force state IDLE, op_result = 0, out_valid = 0, in_ready = 1 after release, clear counter and partial product/quotient registers.
REQ-028 rst asserted during BUSY or DONE SHALL abort the operation; no result for it is ever presented.
REQ-029 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification (XLEN = 32)
REQ-030 ADD a=0xFFFFFFFF b=0x1, out_ready=1 -> out_valid one cycle after accept, op_result=0x0, in_ready high the following cycle.
REQ-031 SRA a=0x80000000 b=0x24 -> op_result=0xF8000000 (shamt 4); SLTU a=0x1 b=0xFFFFFFFF -> 0x1; SLT same operands -> 0x0.
REQ-032 MULHU a=b=0xFFFFFFFF -> op_result=0xFFFFFFFE with out_valid exactly 33 cycles after accept; MUL same operands -> 0x00000001; in_ready low throughout BUSY.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000; REM same -> 0x0; DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-034 DIVU a=7 b=0 -> 0xFFFFFFFF; REMU a=7 b=0 -> 0x7; both at 33-cycle latency.
REQ-035 Backpressure and reset: out_ready=0 for 5 cycles after DONE -> op_result stable, in_valid ignored; rst pulse mid-BUSY (cycle 10 of DIVU) -> out_valid=0, op_result=0 immediately, no result appears, next request completes correctly.
